snake_body_unit: RTL and testbench

SNAKE_BODY_UNIT -- requirements
Module: snake_body_unit

---
 rtl/snake_body_unit.sv | 191 +++++++++++++++++++
 tb/tb_snake_body_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_unit.sv
// rtl/snake_body_unit.sv - snake segment store, stepping, collision, scoring and display lookup
module snake_body_unit #(
  parameter int STEP_CYCLES = 12_500_000,
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int MAX_LEN     = 16,
  parameter int INIT_LEN    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key0_right,
  input  logic        key1_left,
  input  logic        key2_down,
  input  logic        key3_up,
  input  logic [1:0]  game_status,
  input  logic [5:0]  food_x,
  input  logic [4:0]  food_y,
  input  logic [5:0]  query_x,
  input  logic [4:0]  query_y,
  output logic        hit_wall,
  output logic        hit_body,
  output logic        food_eaten,
  output logic [11:0] bcd_data,
  output logic [4:0]  snake_len,
  output logic [5:0]  head_x,
  output logic [4:0]  head_y,
  output logic        is_snake,
  output logic        is_head
);

  typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP} dir_t;

  localparam logic [1:0] GS_RESTART = 2'b00;
  localparam logic [1:0] GS_START   = 2'b01;
  localparam logic [1:0] GS_PLAY    = 2'b10;
  localparam int         CW         = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [5:0]    seg_x [MAX_LEN];
  logic [4:0]    seg_y [MAX_LEN];
  logic [4:0]    len_q;
  dir_t          dir_q;
  dir_t          pend_q;
  logic [CW-1:0] cnt_q;

  logic          step_now;
  dir_t          ref_dir;
  dir_t          key_dir;
  logic          key_ok;
  logic [5:0]    nx;
  logic [4:0]    ny;
  logic          wall_hit;
  logic          food_hit;
  logic          body_hit;
  logic          q_any;
  logic          q_head;

  // Saturating three-digit BCD increment.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Step decision: key filtering against the direction in force, next head, collisions.
  always_comb begin
    step_now = (game_status == GS_PLAY) && (cnt_q == CW'(STEP_CYCLES - 1));
    // On a step cycle the pending direction becomes committed, so keys are judged against it.
    ref_dir  = step_now ? pend_q : dir_q;
    key_dir  = DIR_RIGHT;
    key_ok   = 1'b0;
    if (!key3_up) begin
      key_dir = DIR_UP;
      key_ok  = (ref_dir != DIR_DOWN);
    end else if (!key2_down) begin
      key_dir = DIR_DOWN;
      key_ok  = (ref_dir != DIR_UP);
    end else if (!key1_left) begin
      key_dir = DIR_LEFT;
      key_ok  = (ref_dir != DIR_RIGHT);
    end else if (!key0_right) begin
      key_dir = DIR_RIGHT;
      key_ok  = (ref_dir != DIR_LEFT);
    end

    nx       = seg_x[0];
    ny       = seg_y[0];
    wall_hit = 1'b0;
    case (pend_q)
      DIR_RIGHT: begin wall_hit = (seg_x[0] == 6'(GRID_W - 1)); nx = seg_x[0] + 6'd1; end
      DIR_LEFT:  begin wall_hit = (seg_x[0] == 6'd0);           nx = seg_x[0] - 6'd1; end
      DIR_DOWN:  begin wall_hit = (seg_y[0] == 5'(GRID_H - 1)); ny = seg_y[0] + 5'd1; end
      default:   begin wall_hit = (seg_y[0] == 5'd0);           ny = seg_y[0] - 5'd1; end
    endcase
    food_hit = (nx == food_x) && (ny == food_y);

    // The tail vacates on a normal step, but stays put when the snake grows.
    body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i < int'(len_q)) && (food_hit || (i < int'(len_q) - 1)) &&
          (seg_x[i] == nx) && (seg_y[i] == ny)) begin
        body_hit = 1'b1;
      end
    end
  end

  // Display lookup match against active segments.
  always_comb begin
    q_any  = 1'b0;
    q_head = (seg_x[0] == query_x) && (seg_y[0] == query_y);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(len_q)) && (seg_x[i] == query_x) && (seg_y[i] == query_y)) begin
        q_any = 1'b1;
      end
    end
  end

  // Game state: init on reset/RESTART, direction latching, step timing, moves and scoring.
  always_ff @(posedge clk) begin
    food_eaten <= 1'b0;
    if (rst || (game_status == GS_RESTART)) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 6'(20 - i);
        seg_y[i] <= 5'd15;
      end
      len_q    <= 5'(INIT_LEN);
      dir_q    <= DIR_RIGHT;
      pend_q   <= DIR_RIGHT;
      cnt_q    <= '0;
      hit_wall <= 1'b0;
      hit_body <= 1'b0;
      bcd_data <= 12'h000;
    end else if (game_status == GS_START) begin
      cnt_q <= '0;
      if (key_ok) pend_q <= key_dir;
    end else if (game_status == GS_PLAY) begin
      if (key_ok) pend_q <= key_dir;
      if (step_now) begin
        cnt_q <= '0;
        dir_q <= pend_q;
        if (wall_hit) begin
          hit_wall <= 1'b1;
        end else if (body_hit) begin
          hit_body <= 1'b1;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          if (food_hit) begin
            if (len_q != 5'(MAX_LEN)) len_q <= len_q + 5'd1;
            bcd_data   <= bcd_inc(bcd_data);
            food_eaten <= 1'b1;
          end
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Registered lookup result, one cycle behind the query.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_snake <= 1'b0;
      is_head  <= 1'b0;
    end else begin
      is_snake <= q_any;
      is_head  <= q_head;
    end
  end

  assign snake_len = len_q;
  assign head_x    = seg_x[0];
  assign head_y    = seg_y[0];

endmodule

// File: tb/tb_snake_body_unit.sv
// tb/tb_snake_body_unit.sv - directed self-checking bench for snake_body_unit
module tb_snake_body_unit;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key0_right, key1_left, key2_down, key3_up;
  logic [1:0]  game_status;
  logic [5:0]  food_x, query_x;
  logic [4:0]  food_y, query_y;
  logic        hit_wall, hit_body, food_eaten, is_snake, is_head;
  logic [11:0] bcd_data;
  logic [4:0]  snake_len;
  logic [5:0]  head_x;
  logic [4:0]  head_y;

  int checks   = 0;
  int failures = 0;

  snake_body_unit #(.STEP_CYCLES(SC), .GRID_W(40), .GRID_H(30), .MAX_LEN(16), .INIT_LEN(3)) dut (
    .clk(clk), .rst(rst),
    .key0_right(key0_right), .key1_left(key1_left), .key2_down(key2_down), .key3_up(key3_up),
    .game_status(game_status), .food_x(food_x), .food_y(food_y),
    .query_x(query_x), .query_y(query_y),
    .hit_wall(hit_wall), .hit_body(hit_body), .food_eaten(food_eaten), .bcd_data(bcd_data),
    .snake_len(snake_len), .head_x(head_x), .head_y(head_y),
    .is_snake(is_snake), .is_head(is_head)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Arguments are "pressed" flags; the keys themselves are active-low.
  task automatic keys(input logic r, input logic l, input logic d, input logic u);
    key0_right = ~r;
    key1_left  = ~l;
    key2_down  = ~d;
    key3_up    = ~u;
  endtask

  task automatic head_is(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(head_x), 32'(x));
    check({tag, "_y"}, 32'(head_y), 32'(y));
  endtask

  // 0 right, 1 left, 2 down, 3 up
  int hx, hy, hdir, vdir, nxm, nym;

  initial begin
    rst = 1'b1; game_status = 2'b00; keys(0, 0, 0, 0);
    food_x = 6'd0; food_y = 5'd0; query_x = 6'd19; query_y = 5'd15;
    @(posedge clk); #1;
    tick(1);
    check("rst_len", 32'(snake_len), 32'd3);
    head_is("rst_head", 20, 15);
    check("rst_wall", 32'(hit_wall), 32'd0);
    check("rst_body", 32'(hit_body), 32'd0);
    check("rst_bcd", 32'(bcd_data), 32'h000);
    check("rst_food", 32'(food_eaten), 32'd0);
    check("rst_snake", 32'(is_snake), 32'd0);
    check("rst_ishead", 32'(is_head), 32'd0);

    // Lookup after reset
    rst = 1'b0;
    tick(1);
    check("q19_snake", 32'(is_snake), 32'd1);
    check("q19_head", 32'(is_head), 32'd0);
    query_x = 6'd20;
    tick(1);
    check("q20_snake", 32'(is_snake), 32'd1);
    check("q20_head", 32'(is_head), 32'd1);
    query_x = 6'd17;
    tick(1);
    check("q17_inactive", 32'(is_snake), 32'd0);

    // Straight run into the right wall
    game_status = 2'b10;
    tick(SC - 1);
    head_is("pre_step", 20, 15);
    tick(1);
    head_is("first_step", 21, 15);
    tick(SC * 18);
    head_is("at_edge", 39, 15);
    check("edge_nowall", 32'(hit_wall), 32'd0);
    tick(SC);
    check("wall_set", 32'(hit_wall), 32'd1);
    head_is("wall_hold", 39, 15);
    tick(SC);
    check("wall_sticky", 32'(hit_wall), 32'd1);
    game_status = 2'b00;
    tick(1);
    check("restart_wall", 32'(hit_wall), 32'd0);
    head_is("restart_head", 20, 15);

    // Direction keys
    game_status = 2'b10;
    keys(0, 1, 0, 0);
    tick(SC);
    head_is("left_ignored", 21, 15);
    keys(1, 0, 0, 1);
    tick(SC);
    head_is("up1", 21, 14);
    tick(SC);
    head_is("up2", 21, 13);
    keys(0, 0, 0, 0);

    // Food on the second step
    game_status = 2'b00; food_x = 6'd22; food_y = 5'd15;
    tick(1);
    game_status = 2'b10;
    tick(SC);
    check("food_len_before", 32'(snake_len), 32'd3);
    tick(SC);
    check("food_len", 32'(snake_len), 32'd4);
    check("food_bcd", 32'(bcd_data), 32'h001);
    check("food_pulse", 32'(food_eaten), 32'd1);
    head_is("food_head", 22, 15);
    query_x = 6'd19; query_y = 5'd15;
    tick(1);
    check("food_pulse_end", 32'(food_eaten), 32'd0);
    check("tail_kept", 32'(is_snake), 32'd1);

    // Grow to 5, then turn back into the body
    game_status = 2'b00; food_x = 6'd21; food_y = 5'd15;
    tick(1);
    game_status = 2'b10;
    tick(SC);
    food_x = 6'd22;
    tick(SC);
    check("len5", 32'(snake_len), 32'd5);
    food_x = 6'd0; food_y = 5'd0;
    keys(0, 0, 1, 0);
    tick(SC);
    head_is("turn_down", 22, 16);
    keys(0, 1, 0, 0);
    tick(SC);
    head_is("turn_left", 21, 16);
    keys(0, 0, 0, 1);
    tick(SC);
    check("body_set", 32'(hit_body), 32'd1);
    check("body_nowall", 32'(hit_wall), 32'd0);
    head_is("body_hold", 21, 16);
    check("body_len", 32'(snake_len), 32'd5);
    keys(0, 0, 0, 0);
    game_status = 2'b11;
    tick(100);
    head_is("die_head", 21, 16);
    check("die_len", 32'(snake_len), 32'd5);
    check("die_bcd", 32'(bcd_data), 32'h002);
    check("die_body", 32'(hit_body), 32'd1);
    game_status = 2'b00;
    tick(1);
    check("rs_body", 32'(hit_body), 32'd0);
    check("rs_len", 32'(snake_len), 32'd3);
    check("rs_bcd", 32'(bcd_data), 32'h000);
    head_is("rs_head", 20, 15);

    // Serpentine with food placed on every next cell to drive the score
    hx = 20; hy = 15; hdir = 0; vdir = 2;
    game_status = 2'b10;
    for (int n = 1; n <= 1001; n++) begin
      if (hdir == 2 || hdir == 3) begin
        hdir = (hx == 39) ? 1 : 0;
      end else if ((hdir == 0 && hx == 39) || (hdir == 1 && hx == 0)) begin
        if (vdir == 2 && hy == 29) vdir = 3;
        else if (vdir == 3 && hy == 0) vdir = 2;
        hdir = vdir;
      end
      nxm = hx + ((hdir == 0) ? 1 : (hdir == 1) ? -1 : 0);
      nym = hy + ((hdir == 2) ? 1 : (hdir == 3) ? -1 : 0);
      keys(hdir == 0, hdir == 1, hdir == 2, hdir == 3);
      food_x = 6'(nxm); food_y = 5'(nym);
      tick(SC);
      hx = nxm; hy = nym;
      if (n == 99)   check("bcd_099", 32'(bcd_data), 32'h099);
      if (n == 100)  check("bcd_100", 32'(bcd_data), 32'h100);
      if (n == 500)  head_is("serp_head", hx, hy);
      if (n == 999)  check("bcd_999", 32'(bcd_data), 32'h999);
      if (n == 1001) begin
        check("bcd_sat", 32'(bcd_data), 32'h999);
        check("len_sat", 32'(snake_len), 32'd16);
        check("serp_nowall", 32'(hit_wall), 32'd0);
        check("serp_nobody", 32'(hit_body), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
